sra_srl_seq: RTL and testbench

- Multi-cycle 32-bit right shifter: logical (zero-fill) or arithmetic (sign-fill). Counterpart to the combinational left barrel shifter.
- Applies one log-stage per clock (16, 8, 4, 2, 1), so the ALU shift path needs only one stage of muxes instead of five in series.
- Sits beside the ALU. The pipeline control stalls on `busy` and consumes the result on `done`.

---
 rtl/sra_srl_seq.sv | 103 ++++++++++
 tb/tb_sra_srl_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sra_srl_seq.sv
// Multi-cycle 32-bit right shifter, logical or arithmetic.
// One log-stage per clock (16, 8, 4, 2, 1); result and done appear the cycle after the fifth stage.
module sra_srl_seq #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  in,
  input  logic [STAGES-1:0] amt,
  input  logic              arith,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              done
);

  localparam int KW = $clog2(STAGES);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [STAGES-1:0] amt_q, amt_d;
  logic              fill_q, fill_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  stage_val;

  // Shift right by 2^k, filling the vacated top bits with f.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] w,
                                                   input logic [KW-1:0] k,
                                                   input logic f);
    logic [STAGES:0]    sh;
    logic [WIDTH-1:0]   ones;
    logic [WIDTH-1:0]   fill_mask;
    sh        = (STAGES+1)'(1) << k;
    ones      = '1;
    fill_mask = ~(ones >> sh);
    return (w >> sh) | (f ? fill_mask : '0);
  endfunction

  assign stage_val = amt_q[k_q] ? stage_shift(work_q, k_q, fill_q) : work_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    work_d  = work_q;
    amt_d   = amt_q;
    fill_d  = fill_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = in;
          amt_d   = amt;
          fill_d  = arith & in[WIDTH-1];
          k_d     = KW'(STAGES-1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = stage_val;
        // Last stage: publish the result directly so out never shows partial values.
        if (k_q == '0) begin
          out_d   = stage_val;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      work_q  <= '0;
      amt_q   <= '0;
      fill_q  <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_sra_srl_seq.sv
// Directed bench for sra_srl_seq: latency, fill modes, busy-ignore, back-to-back and abort.
module tb_sra_srl_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in;
  logic [4:0]  amt;
  logic        arith;
  logic [31:0] out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  sra_srl_seq #(.WIDTH(32), .STAGES(5)) dut (
    .clock(clock), .reset(reset), .start(start), .in(in), .amt(amt),
    .arith(arith), .out(out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Pulse start for one edge, then scramble operands to prove only captured copies matter.
  task automatic launch(input logic [31:0] d, input logic [4:0] a, input logic ar);
    in = d; amt = a; arith = ar; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    in = $urandom; amt = 5'($urandom); arith = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; in = 32'hFFFF_FFFF; amt = 5'd3; arith = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out=%h busy=%b done=%b, want out=0 busy=0 done=0", out, busy, done);
    end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_start: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] v_in  [9] = '{32'h8000_0000, 32'h8000_0000, 32'hF0F0_F0F0, 32'h70F0_F0F0,
                               32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
                               32'hAAAA_AAAA};
    logic [4:0]  v_amt [9] = '{5'd31, 5'd31, 5'd4, 5'd4, 5'd16, 5'd0, 5'd0, 5'd1, 5'd31};
    logic        v_ar  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] v_exp [9] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFF0F_0F0F, 32'h070F_0F0F,
                               32'h0000_1234, 32'h1234_5678, 32'h8000_0000, 32'hC000_0000,
                               32'h0000_0001};
    logic [31:0] prev;
    int          bad;
    for (int v = 0; v < 9; v++) begin
      prev = out;
      launch(v_in[v], v_amt[v], v_ar[v]);
      bad = 0;
      for (int c = 0; c < 5; c++) begin
        if (busy !== 1'b1 || done !== 1'b0 || out !== prev) bad++;
        if (c < 4) begin @(posedge clock); #1; end
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL vec%0d_busy_window: %0d bad cycles (busy/done/out-hold), want 0", v, bad);
      end
      @(posedge clock); #1;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || out !== v_exp[v]) begin
        n_fail++;
        $display("FAIL vec%0d_result: done=%b busy=%b out=%h, want done=1 busy=0 out=%h",
                 v, done, busy, out, v_exp[v]);
      end
      @(posedge clock); #1;
      n_checks++;
      if (done !== 1'b0 || out !== v_exp[v]) begin
        n_fail++;
        $display("FAIL vec%0d_after: done=%b out=%h, want done=0 out=%h", v, done, out, v_exp[v]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int pulses;
    launch(32'hDEAD_BEEF, 5'd8, 1'b0);
    @(posedge clock); #1;
    start = 1'b1; in = 32'h0; amt = 5'd1; arith = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_midway: done=%b busy=%b, want done=0 busy=1", done, busy);
    end
    @(posedge clock); #1;
    n_checks++;
    if (done !== 1'b1 || out !== 32'h00DE_ADBE) begin
      n_fail++;
      $display("FAIL ignore_result: done=%b out=%h, want done=1 out=00deadbe", done, out);
    end
    pulses = 0;
    repeat (7) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || out !== 32'h00DE_ADBE) begin
      n_fail++;
      $display("FAIL ignore_no_second: extra activity=%0d out=%h, want 0 and out=00deadbe", pulses, out);
    end
  endtask

  task automatic test_back_to_back();
    launch(32'hFFFF_0000, 5'd1, 1'b0);
    repeat (5) begin @(posedge clock); #1; end
    n_checks++;
    if (done !== 1'b1 || out !== 32'h7FFF_8000) begin
      n_fail++;
      $display("FAIL b2b_A: done=%b out=%h, want done=1 out=7fff8000", done, out);
    end
    launch(32'h0000_0100, 5'd8, 1'b1);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: done=%b busy=%b, want done=0 busy=1", done, busy);
    end
    repeat (4) begin @(posedge clock); #1; end
    n_checks++;
    if (done !== 1'b0 || out !== 32'h7FFF_8000) begin
      n_fail++;
      $display("FAIL b2b_B_early: done=%b out=%h, want done=0 out=7fff8000", done, out);
    end
    @(posedge clock); #1;
    n_checks++;
    if (done !== 1'b1 || out !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL b2b_B: done=%b out=%h, want done=1 out=00000001", done, out);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    launch(32'h1234_5678, 5'd4, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n_checks++;
    if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: out=%h busy=%b done=%b, want 0/0/0", out, busy, done);
    end
    pulses = 0;
    repeat (6) begin
      @(posedge clock); #1;
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: done pulses=%0d, want 0", pulses);
    end
    launch(32'h8000_FFFF, 5'd4, 1'b1);
    repeat (4) begin @(posedge clock); #1; end
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_fresh_early: done=%b busy=%b, want done=0 busy=1", done, busy);
    end
    @(posedge clock); #1;
    n_checks++;
    if (done !== 1'b1 || out !== 32'hF800_0FFF) begin
      n_fail++;
      $display("FAIL abort_fresh: done=%b out=%h, want done=1 out=f8000fff", done, out);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in = '0; amt = '0; arith = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_vectors();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
